// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe engine that debounces keypad codes, owns the board and detects win/draw.
//   clk, rst (async, active-high)
//   game_en      : 1 = game mode, 0 = title mode (forces IDLE, clears game)
//   key_data[3:0]: scanner code, 1-9 cells, 10 = left, 11 = right
//   board[17:0]  : cell k at [2k-1:2k-2], 00 empty, 01 X, 10 O
//   turn_o, winner[1:0], game_over, move_count[3:0], move_pulse, reject_pulse, is_right, state_o[1:0]
//   win_line[8:0]: cells of the completed line(s), present only when WIN_LINE_EN is defined
module ttt_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic [3:0]  key_data,
    output logic [17:0] board,
    output logic        turn_o,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [3:0]  move_count,
    output logic        move_pulse,
    output logic        reject_pulse,
    output logic        is_right,
`ifdef WIN_LINE_EN
    output logic [8:0]  win_line,
`endif
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [8:0] LINES [8] = '{9'b000000111, 9'b000111000, 9'b111000000, 9'b001001001,
                                          9'b010010010, 9'b100100100, 9'b100010001, 9'b001010100};
    state_t state_q, state_d;
    logic [3:0] kd_q, kd_prev_q, pcode_q, mc_q, mc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic armed_q, armed_d, press_q, press_d, hit;
    logic [17:0] board_q, board_d;
    logic turn_q, turn_d, mp_q, mp_d, rj_q, rj_d, right_q, right_d, over_q, over_d;
    logic [1:0] winner_q, winner_d, mover;
    logic [4:0] pos;
    logic is_cell;
    logic [8:0] own, line_or;
    // A press fires once when a nonzero code first becomes stable; only a stable zero rearms.
    always_comb begin
        cnt_d   = (kd_q != kd_prev_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        hit     = (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);
        press_d = hit && (kd_q != 4'd0) && armed_q;
        armed_d = hit ? (kd_q == 4'd0) : armed_q;
        right_d = (press_q && pcode_q == 4'd10) ? 1'b0 : (press_q && pcode_q == 4'd11) ? 1'b1 : right_q;
    end
    always_comb begin
        mover   = turn_q ? 2'b10 : 2'b01;
        pos     = {pcode_q, 1'b0} - 5'd2;
        is_cell = (pcode_q >= 4'd1) && (pcode_q <= 4'd9);
        own     = '0;
        line_or = '0;
        for (int i = 0; i < 9; i++) own[i] = (board_q[2*i +: 2] == mover);
        for (int i = 0; i < 8; i++) if ((own & LINES[i]) == LINES[i]) line_or = line_or | LINES[i];
    end
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        mc_d     = mc_q;
        mp_d     = 1'b0;
        rj_d     = 1'b0;
        case (state_q)
            IDLE: begin
                board_d  = '0;
                winner_d = 2'b00;
                mc_d     = 4'd0;
                turn_d   = 1'b0;
                if (game_en) state_d = PLAY;
            end
            PLAY: begin
                if (press_q && is_cell) begin
                    if (board_q[pos +: 2] == 2'b00) begin
                        board_d[pos +: 2] = mover;
                        mc_d    = (mc_q == 4'd9) ? mc_q : mc_q + 4'd1;
                        mp_d    = 1'b1;
                        state_d = CHECK;
                    end else begin
                        rj_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (|line_or) begin
                    winner_d = mover;
                    state_d  = OVER;
                end else if (mc_q == 4'd9) begin
                    winner_d = 2'b11;
                    state_d  = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            default: ;
        endcase
        if (!game_en) begin
            state_d  = IDLE;
            board_d  = '0;
            winner_d = 2'b00;
            mc_d     = 4'd0;
            turn_d   = 1'b0;
            mp_d     = 1'b0;
            rj_d     = 1'b0;
        end
        over_d = (state_d == OVER);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kd_q      <= '0;
            kd_prev_q <= '0;
            pcode_q   <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            press_q   <= 1'b0;
            state_q   <= IDLE;
            board_q   <= '0;
            turn_q    <= 1'b0;
            winner_q  <= 2'b00;
            mc_q      <= 4'd0;
            mp_q      <= 1'b0;
            rj_q      <= 1'b0;
            right_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            kd_q      <= key_data;
            kd_prev_q <= kd_q;
            pcode_q   <= kd_q;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
            state_q   <= state_d;
            board_q   <= board_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            rj_q      <= rj_d;
            right_q   <= right_d;
            over_q    <= over_d;
        end
    end
`ifdef WIN_LINE_EN
    logic [8:0] wl_q, wl_d;
    always_comb wl_d = !game_en ? 9'd0 : (state_q == CHECK) ? line_or : wl_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wl_q <= '0;
        else     wl_q <= wl_d;
    end
    assign win_line = wl_q;
`endif
    assign board        = board_q;
    assign turn_o       = turn_q;
    assign winner       = winner_q;
    assign game_over    = over_q;
    assign move_count   = mc_q;
    assign move_pulse   = mp_q;
    assign reject_pulse = rj_q;
    assign is_right     = right_q;
    assign state_o      = state_q;
endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Tic-tac-toe game engine, directly downstream of the keypad scanner.
- Consumes the scanner's level-type `key_data` code, debounces it and turns each press into a single event.
- Owns the 18-bit board, turn, move count, win/draw detection and the board left/right position flag.
- Its board and status outputs feed the dot-matrix and 7-segment display stages.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clk cycles a `key_data` value must hold to count as stable (10 ms at 25 MHz); minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, never overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- game_en  in  1  1 = game mode, 0 = main/title mode
- key_data  in  4  scanner code: 0 none/key_0, 1-9 cells, 10 key_*, 11 key_#; 12-15 ignored
- board  out  18  cell k (1..9) at bits [2k-1:2k-2]; 00 empty, 01 X, 10 O
- turn_o  out  1  0 = X to move, 1 = O to move
- winner  out  2  00 none, 01 X, 10 O, 11 draw
- game_over  out  1  high in OVER state
- move_count  out  4  stones placed, 0-9
- move_pulse  out  1  one-cycle strobe when a stone is written
- reject_pulse  out  1  one-cycle strobe on a press to an occupied cell
- is_right  out  1  board display offset; 1 = right, 0 = left
- state_o  out  2  00 IDLE, 01 PLAY, 10 CHECK, 11 OVER

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM in IDLE; debounce counter 0; press detector armed.
- Debounce:
  - `key_data` is registered once into `kd_q`; the counter increments while `kd_q` equals its previous value and reloads to 0 on any change.
  - A press event fires for exactly one cycle on the edge where the count reaches DEBOUNCE_CYCLES with `kd_q` nonzero and the detector armed; the detector then disarms.
  - The detector rearms when `kd_q` = 0 has held for DEBOUNCE_CYCLES cycles.
  - A held key gives exactly one event. A code change while held restarts the count but stays disarmed, so it gives no event.
- Codes 10 and 11 set `is_right` to 0 and 1 respectively, in any state including IDLE. They do not affect the FSM.
- IDLE:
  - `board`, `winner` and `move_count` are held at 0; `turn_o` = 0.
  - When `game_en` = 1, go to PLAY on the next edge.
- PLAY, on a press event with code 1-9:
  - Target cell empty: write 01 if `turn_o` = 0, else 10; increment `move_count`; assert `move_pulse`; go to CHECK. All take effect on the edge after the event.
  - Target cell occupied: assert `reject_pulse` for one cycle; no state change.
- CHECK (exactly one cycle) evaluates the 8 lines (rows 123, 456, 789; columns 147, 258, 369; diagonals 159, 357):
  - Line owned by the mover: `winner` = mover, go to OVER.
  - Otherwise, if `move_count` = 9: `winner` = 11, go to OVER.
  - Otherwise: toggle `turn_o`, return to PLAY.
  - `turn_o` is not toggled on a win or draw.
- OVER:
  - Presses 1-9 are ignored, with no `reject_pulse`.
  - `key_data` = 0 cannot produce a press event (the detector requires a nonzero code), so a new game never starts from a key press here.
  - `game_en` falling is the only exit from OVER (see next rule).
- `game_en` = 0 in any state: go to IDLE on the next edge and clear the board, `winner`, `move_count` and `turn_o`. This takes priority over a simultaneous press event.
- A press event arriving while in CHECK is dropped.
- `move_count` saturates at 9.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- WIN_LINE_EN
  - Defined: adds output `win_line` [8:0], one bit per cell (bit k-1 = cell k). Set in CHECK to the OR of all lines completed by the mover (a double win sets both lines). Cleared on reset and on entry to IDLE. Held through OVER.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (bench sets DEBOUNCE_CYCLES = 4):
- Reset, then `game_en` = 1 → `state_o` 00 → 01 after 1 edge; `board` = 0, `turn_o` = 0, `winner` = 00.
- Hold `key_data` = 5 for 20 cycles → exactly one `move_pulse`; `board` = 18'h00100 (cell 5 = 01); `turn_o` = 1 after CHECK; `move_count` = 1.
- Release to 0 for 4 cycles, press 5 again → `reject_pulse` for 1 cycle; `board` unchanged; `turn_o` = 1.
- Moves X1, O4, X2, O5, X3 → after the last CHECK `winner` = 01, `game_over` = 1, `state_o` = 11, `move_count` = 5; a further press of 9 leaves `board` unchanged; with WIN_LINE_EN, `win_line` = 9'b000000111.
- Moves X1 O2 X3 O5 X4 O6 X8 O7 X9 → `winner` = 11, `move_count` = 9, `board` = 18'b01_01_10_10_10_01_01_10_01.
- Mid-game: press 11 → `is_right` = 1, board unchanged. Drop `game_en` while a press is stable → next edge `state_o` = 00, `board` = 0, no `move_pulse`. Assert `rst` mid-debounce → all outputs 0 immediately.
